memory_stage: RTL and testbench

Pipeline stage directly downstream of the execute stage in the 5-stage MIPS core. Holds the EX/MEM pipeline register, performs the data-memory load/store through a ready-handshake port that may insert wait states, and drives the MEM/WB pipeline register toward writeback. Publishes the EX/MEM ALU result and destination for forwarding, and a busy signal the hazard unit uses to freeze upstream stages.

---
 rtl/memory_stage.sv | 202 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS core: EX/MEM register, ready-handshake data-memory access, MEM/WB register.
// Optional request timeout/abort is compiled in with `define DMEM_TIMEOUT_EN.
//
// Handshake: dmem_req_o is held, with stable we/addr/wdata, until a cycle where dmem_req_o and
// dmem_ready_i are both high; that cycle completes the access (dmem_rdata_i is valid in it).
// dmem_ready_i while dmem_req_o is low is ignored. A reset may drop dmem_req_o mid-request.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  control_e_i,
    input  logic [31:0] alu_result_e_i,
    input  logic [31:0] mem_write_data_e_i,
    input  logic [4:0]  reg_write_addr_e_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        mem_busy_o,
    output logic        mem_err_o,
    output logic [31:0] alu_result_m,
    output logic        reg_we_m,
    output logic [4:0]  reg_write_addr_m,
    output logic        reg_we_w,
    output logic        sel_reg_write_data_w,
    output logic [31:0] alu_result_w,
    output logic [31:0] read_data_w,
    output logic [4:0]  reg_write_addr_w,
    output logic [1:0]  state_dbg_o
);

`ifdef DMEM_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ABORT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1} state_t;
`endif

    state_t state_q, state_d;

    // EX/MEM pipeline register
    logic        reg_we_m_q, reg_we_m_d;
    logic        sel_m_q, sel_m_d;
    logic        mem_we_m_q, mem_we_m_d;
    logic [31:0] alu_m_q, alu_m_d;
    logic [31:0] wdata_m_q, wdata_m_d;
    logic [4:0]  waddr_m_q, waddr_m_d;

    // MEM/WB pipeline register
    logic        reg_we_w_q, reg_we_w_d;
    logic        sel_w_q, sel_w_d;
    logic [31:0] alu_w_q, alu_w_d;
    logic [31:0] rdata_w_q, rdata_w_d;
    logic [4:0]  waddr_w_q, waddr_w_d;

    logic access_m;
    logic abort_s;
    logic done;
    logic timeout_hit;

    assign access_m = mem_we_m_q | sel_m_q;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q, err_d;

    assign abort_s     = (state_q == ABORT);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    // The incremented count reaching TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES busy cycles.
    assign timeout_hit = (state_q == WAIT) & ~done & (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d       = (state_q == WAIT) ? cnt_inc : '0;
    assign err_d       = err_q | timeout_hit;
    assign mem_err_o   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign abort_s            = 1'b0;
    assign timeout_hit        = 1'b0;
    assign mem_err_o          = 1'b0;
`endif

    assign dmem_req_o   = access_m & ~abort_s;
    assign dmem_we_o    = mem_we_m_q;
    assign dmem_addr_o  = {alu_m_q[31:2], 2'b00};
    assign dmem_wdata_o = wdata_m_q;
    assign done         = dmem_req_o & dmem_ready_i;
    assign mem_busy_o   = access_m & ~done & ~abort_s;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (access_m & ~done) state_d = WAIT;
            WAIT: begin
                if (done) state_d = IDLE;
                else if (timeout_hit) begin
`ifdef DMEM_TIMEOUT_EN
                    state_d = ABORT;
`else
                    state_d = WAIT;
`endif
                end
            end
`ifdef DMEM_TIMEOUT_EN
            ABORT: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_we_m_d = reg_we_m_q;
        sel_m_d    = sel_m_q;
        mem_we_m_d = mem_we_m_q;
        alu_m_d    = alu_m_q;
        wdata_m_d  = wdata_m_q;
        waddr_m_d  = waddr_m_q;
        if (!mem_busy_o) begin
            reg_we_m_d = control_e_i[2];
            sel_m_d    = control_e_i[1];
            mem_we_m_d = control_e_i[0];
            alu_m_d    = alu_result_e_i;
            wdata_m_d  = mem_write_data_e_i;
            waddr_m_d  = reg_write_addr_e_i;
        end
    end

    // A stalled or aborted access retires as a bubble; data fields simply hold.
    always_comb begin
        reg_we_w_d = reg_we_w_q;
        sel_w_d    = sel_w_q;
        alu_w_d    = alu_w_q;
        rdata_w_d  = rdata_w_q;
        waddr_w_d  = waddr_w_q;
        if (mem_busy_o || abort_s) begin
            reg_we_w_d = 1'b0;
            sel_w_d    = 1'b0;
        end else begin
            reg_we_w_d = reg_we_m_q;
            sel_w_d    = sel_m_q;
            alu_w_d    = alu_m_q;
            waddr_w_d  = waddr_m_q;
            if (done) rdata_w_d = dmem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            reg_we_m_q <= 1'b0;
            sel_m_q    <= 1'b0;
            mem_we_m_q <= 1'b0;
            alu_m_q    <= '0;
            wdata_m_q  <= '0;
            waddr_m_q  <= '0;
            reg_we_w_q <= 1'b0;
            sel_w_q    <= 1'b0;
            alu_w_q    <= '0;
            rdata_w_q  <= '0;
            waddr_w_q  <= '0;
        end else begin
            state_q    <= state_d;
            reg_we_m_q <= reg_we_m_d;
            sel_m_q    <= sel_m_d;
            mem_we_m_q <= mem_we_m_d;
            alu_m_q    <= alu_m_d;
            wdata_m_q  <= wdata_m_d;
            waddr_m_q  <= waddr_m_d;
            reg_we_w_q <= reg_we_w_d;
            sel_w_q    <= sel_w_d;
            alu_w_q    <= alu_w_d;
            rdata_w_q  <= rdata_w_d;
            waddr_w_q  <= waddr_w_d;
        end
    end

    assign alu_result_m         = alu_m_q;
    assign reg_we_m             = reg_we_m_q;
    assign reg_write_addr_m     = waddr_m_q;
    assign reg_we_w             = reg_we_w_q;
    assign sel_reg_write_data_w = sel_w_q;
    assign alu_result_w         = alu_w_q;
    assign read_data_w          = rdata_w_q;
    assign reg_write_addr_w     = waddr_w_q;
    assign state_dbg_o          = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: EX/MEM hold, wait states, back-to-back accesses, reset mid-access.
// MEM/WB results are predicted into a scoreboard queue when the completing cycle is driven.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  control_e;
    logic [31:0] alu_result_e;
    logic [31:0] mem_write_data_e;
    logic [4:0]  reg_write_addr_e;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_busy, mem_err;
    logic [31:0] alu_result_m;
    logic        reg_we_m;
    logic [4:0]  reg_write_addr_m;
    logic        reg_we_w, sel_reg_write_data_w;
    logic [31:0] alu_result_w, read_data_w;
    logic [4:0]  reg_write_addr_w;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    logic [70:0] exp_q[$];

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .control_e_i(control_e), .alu_result_e_i(alu_result_e),
        .mem_write_data_e_i(mem_write_data_e), .reg_write_addr_e_i(reg_write_addr_e),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_ready_i(dmem_ready), .dmem_rdata_i(dmem_rdata),
        .mem_busy_o(mem_busy), .mem_err_o(mem_err),
        .alu_result_m(alu_result_m), .reg_we_m(reg_we_m), .reg_write_addr_m(reg_write_addr_m),
        .reg_we_w(reg_we_w), .sel_reg_write_data_w(sel_reg_write_data_w),
        .alu_result_w(alu_result_w), .read_data_w(read_data_w),
        .reg_write_addr_w(reg_write_addr_w), .state_dbg_o(state_dbg)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] wdata, input logic [4:0] waddr);
        control_e        = ctrl;
        alu_result_e     = alu;
        mem_write_data_e = wdata;
        reg_write_addr_e = waddr;
    endtask

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [70:0] wb_word(input logic we, input logic sel, input logic [4:0] a,
                                            input logic [31:0] alu, input logic [31:0] rd);
        return {we, sel, a, alu, rd};
    endfunction

    task automatic push_wb(input logic we, input logic sel, input logic [4:0] a,
                           input logic [31:0] alu, input logic [31:0] rd);
        exp_q.push_back(wb_word(we, sel, a, alu, rd));
    endtask

    task automatic pop_wb(input string tag);
        logic [70:0] obs;
        obs = {reg_we_w, sel_reg_write_data_w, reg_write_addr_w, alu_result_w, read_data_w};
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        drive(3'b000, '0, '0, '0);
        cyc();
        cyc();
        reset = 1'b0;
        check("por_req", 71'(dmem_req), 71'(0));
        check("por_busy", 71'(mem_busy), 71'(0));
        check("por_we_m", 71'(reg_we_m), 71'(0));
        check("por_we_w", 71'(reg_we_w), 71'(0));
        check("por_err", 71'(mem_err), 71'(0));

        // load in flight, then reset held 2 cycles
        drive(3'b110, 32'h80, '0, 5'd2);
        cyc();
        check("inflight_req", 71'(dmem_req), 71'(1));
        check("inflight_busy", 71'(mem_busy), 71'(1));
        reset = 1'b1;
        drive(3'b000, '0, '0, '0);
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_req", 71'(dmem_req), 71'(0));
        check("rst_busy", 71'(mem_busy), 71'(0));
        check("rst_state", 71'(state_dbg), 71'(0));
        check("rst_exmem", 71'({reg_we_m, reg_write_addr_m, alu_result_m}), 71'(0));
        check("rst_memwb", {reg_we_w, sel_reg_write_data_w, reg_write_addr_w, alu_result_w, read_data_w}, 71'(0));

        // ALU op
        drive(3'b100, 32'h1234, '0, 5'd5);
        cyc();
        check("add_alu_m", 71'(alu_result_m), 71'(32'h1234));
        check("add_ex", 71'({reg_we_m, reg_write_addr_m}), 71'({1'b1, 5'd5}));
        check("add_busy", 71'(mem_busy), 71'(0));
        check("add_req", 71'(dmem_req), 71'(0));
        push_wb(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
        drive(3'b000, '0, '0, '0);
        cyc();
        pop_wb("add_wb");
        check("add_alu_m_gone", 71'(alu_result_m), 71'(0));

        // zero-wait load, unaligned address
        drive(3'b110, 32'h103, '0, 5'd7);
        cyc();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        drive(3'b000, '0, '0, '0);
        #1;
        check("ld_req", 71'({dmem_req, dmem_we}), 71'({1'b1, 1'b0}));
        check("ld_addr", 71'(dmem_addr), 71'(32'h100));
        check("ld_busy", 71'(mem_busy), 71'(0));
        push_wb(1'b1, 1'b1, 5'd7, 32'h103, 32'hDEADBEEF);
        cyc();
        pop_wb("ld_wb");
        dmem_ready = 1'b0;
        dmem_rdata = '0;

        // store with 3 wait states; the next instruction waits upstream
        drive(3'b001, 32'h40, 32'hA5A5A5A5, 5'd0);
        cyc();
        drive(3'b100, 32'h77, '0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_busy", 71'(mem_busy), 71'(1));
            check("st_req_we", 71'({dmem_req, dmem_we}), 71'({1'b1, 1'b1}));
            check("st_addr_data", 71'({dmem_addr, dmem_wdata}), 71'({32'h40, 32'hA5A5A5A5}));
            check("st_hold_m", 71'(alu_result_m), 71'(32'h40));
            cyc();
            check("st_bubble", 71'({reg_we_w, sel_reg_write_data_w}), 71'(0));
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h11111111;
        #1;
        check("st_done_busy", 71'(mem_busy), 71'(0));
        check("st_done_req", 71'(dmem_req), 71'(1));
        push_wb(1'b0, 1'b0, 5'd0, 32'h40, 32'h11111111);
        cyc();
        pop_wb("st_wb");
        check("st_next_m", 71'(alu_result_m), 71'(32'h77));
        // ready without a request must not disturb read_data_w
        dmem_rdata = 32'hBAD0BAD0;
        push_wb(1'b1, 1'b0, 5'd9, 32'h77, 32'h11111111);
        drive(3'b000, '0, '0, '0);
        cyc();
        pop_wb("stray_ready_wb");
        dmem_ready = 1'b0;

        // back-to-back loads, ready held high
        drive(3'b110, 32'h200, '0, 5'd3);
        cyc();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hAAAA0001;
        drive(3'b110, 32'h204, '0, 5'd4);
        #1;
        check("b2b_a_req", 71'({dmem_req, mem_busy}), 71'({1'b1, 1'b0}));
        check("b2b_a_addr", 71'(dmem_addr), 71'(32'h200));
        push_wb(1'b1, 1'b1, 5'd3, 32'h200, 32'hAAAA0001);
        cyc();
        pop_wb("b2b_a_wb");
        dmem_rdata = 32'hBBBB0002;
        drive(3'b000, '0, '0, '0);
        #1;
        check("b2b_b_req", 71'({dmem_req, mem_busy}), 71'({1'b1, 1'b0}));
        check("b2b_b_addr", 71'(dmem_addr), 71'(32'h204));
        push_wb(1'b1, 1'b1, 5'd4, 32'h204, 32'hBBBB0002);
        cyc();
        pop_wb("b2b_b_wb");
        dmem_ready = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        // ready never arrives: 4 busy cycles, then one ABORT cycle
        drive(3'b110, 32'h300, '0, 5'd6);
        cyc();
        drive(3'b100, 32'h55, '0, 5'd8);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_busy", 71'(mem_busy), 71'(1));
            check("to_err_low", 71'(mem_err), 71'(0));
            cyc();
        end
        check("to_state_abort", 71'(state_dbg), 71'(2));
        check("to_abort_idle", 71'({dmem_req, mem_busy}), 71'(0));
        check("to_err", 71'(mem_err), 71'(1));
        cyc();
        check("to_bubble", 71'(reg_we_w), 71'(0));
        check("to_next_m", 71'(alu_result_m), 71'(32'h55));
        check("to_err_sticky", 71'(mem_err), 71'(1));
        check("to_state_idle", 71'(state_dbg), 71'(0));
        push_wb(1'b1, 1'b0, 5'd8, 32'h55, 32'hBBBB0002);
        drive(3'b000, '0, '0, '0);
        cyc();
        pop_wb("to_next_wb");
`else
        // long wait: no timeout, the request persists until ready
        drive(3'b110, 32'h500, '0, 5'd10);
        cyc();
        drive(3'b000, '0, '0, '0);
        for (int i = 0; i < 20; i++) begin
            check("lw_busy", 71'({mem_busy, dmem_req}), 71'({1'b1, 1'b1}));
            check("lw_err", 71'(mem_err), 71'(0));
            cyc();
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'hC0FFEE00;
        #1;
        check("lw_done_busy", 71'(mem_busy), 71'(0));
        push_wb(1'b1, 1'b1, 5'd10, 32'h500, 32'hC0FFEE00);
        cyc();
        pop_wb("lw_wb");
        dmem_ready = 1'b0;
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
